// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package rr_arbiter4_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Registered output bundle feeding the downstream decoder
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             dis;
    logic             timeout;
  } arb_out_t;
endpackage

// File: rtl/rr_arbiter4_pick.sv
// Rotating-priority winner search: first set bit of req starting at last+1, wrapping to last.
module rr_pick
  import rr_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   winner
);
  logic [SEL_W-1:0] idx;

  // Walk from farthest to nearest so the nearest set bit overrides
  always_comb begin
    any    = |req;
    winner = last;
    idx    = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter driving a 2-to-4 active-low decoder (sel/dis), registered outputs.
// Define RR_TIMEOUT_EN to force-release grants held for MAX_HOLD cycles.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [SEL_W-1:0]   sel,
  output logic               dis,
  output logic               timeout
);
  state_t           state, state_nx;
  logic [SEL_W-1:0] last, last_nx;
  arb_out_t         q, q_nx;
  logic             any;
  logic [SEL_W-1:0] winner;
  logic             rel_norm, force_rel;

  rr_pick u_pick (
    .req    (req),
    .last   (last),
    .any    (any),
    .winner (winner)
  );

  assign rel_norm = done | ~req[q.sel];

`ifdef RR_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  logic [CNT_W-1:0] cnt;

  assign force_rel = (cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       cnt <= '0;
    else if (state == ST_GRANT && !rel_norm && !force_rel) cnt <= cnt + CNT_W'(1);
    else if (state != ST_GRANT || rel_norm || force_rel)   cnt <= '0;
  end
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    last_nx   = last;
    q_nx      = q;
    q_nx.timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        q_nx.dis = 1'b1;
        if (any) begin
          q_nx.sel = winner;
          q_nx.dis = 1'b0;
          state_nx = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Done or request drop wins over the hold limit: no timeout pulse then
        if (rel_norm || force_rel) begin
          q_nx.dis     = 1'b1;
          q_nx.timeout = force_rel & ~rel_norm;
          last_nx      = q.sel;
          state_nx     = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      last  <= 2'b11;
      q     <= '{sel: 2'b00, dis: 1'b1, timeout: 1'b0};
    end else begin
      state <= state_nx;
      last  <= last_nx;
      q     <= q_nx;
    end
  end

  assign sel     = q.sel;
  assign dis     = q.dis;
  assign timeout = q.timeout;
endmodule
